// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM->WB stage: sideband layout, load/store
// encodings, dcache access sizes and the request FSM state type.
package mem_wb_stage_pkg;

  // m_side = {waddr7, hilo64, hilo_we1, pc32, exc4, is_ds1, tlb_we1, tlb_cp0we2}
  localparam int SIDE_W             = 112;
  localparam int SIDE_TLB_CP0WE_LSB = 0;
  localparam int SIDE_TLB_WE_LSB    = 2;
  localparam int SIDE_IS_DS_LSB     = 3;
  localparam int SIDE_EXC_LSB       = 4;
  localparam int SIDE_EXC_W         = 4;
  localparam int SIDE_PC_LSB        = 8;
  localparam int SIDE_HILO_WE_LSB   = 40;
  localparam int SIDE_HILO_LSB      = 41;
  localparam int SIDE_WADDR_LSB     = 105;

  localparam logic [2:0] RT_W  = 3'd0;
  localparam logic [2:0] RT_B  = 3'd1;
  localparam logic [2:0] RT_BU = 3'd2;
  localparam logic [2:0] RT_H  = 3'd3;
  localparam logic [2:0] RT_HU = 3'd4;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_DROP = 3'd4
  } state_e;

  function automatic logic [1:0] size_of(input logic [2:0] rt);
    case (rt)
      RT_B, RT_BU: size_of = SIZE_B;
      RT_H, RT_HU: size_of = SIZE_H;
      default:     size_of = SIZE_W;
    endcase
  endfunction

  // Stores drive every byte lane so the dcache can pick by address.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SIZE_B:  store_lanes = {4{d[7:0]}};
      SIZE_H:  store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load-data lane select and sign/zero extension by readtype and address LSBs.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  readtype_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte lane select.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
  end

  assign half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Extension; unknown readtypes fall back to a full word.
  always_comb begin
    case (readtype_i)
      RT_B:    data_o = {{24{byte_s[7]}}, byte_s};
      RT_BU:   data_o = {24'd0, byte_s};
      RT_H:    data_o = {{16{half_s[15]}}, half_s};
      RT_HU:   data_o = {16'd0, half_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: issues dcache requests for loads/stores, tracks the
// handshake with a small FSM and registers the retiring instruction into WB.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              m_valid,
  input  logic [31:0]       m_aluout,
  input  logic [31:0]       m_wdata,
  input  logic              m_memtoreg,
  input  logic              m_regwrite,
  input  logic              m_memwrite,
  input  logic [2:0]        m_readtype,
  input  logic [SIDE_W-1:0] m_side,
  output logic              dcache_req,
  output logic              dcache_wr,
  output logic [1:0]        dcache_size,
  output logic [31:0]       dcache_addr,
  output logic [31:0]       dcache_wdata,
  input  logic              dcache_addr_ok,
  input  logic              dcache_data_ok,
  input  logic [31:0]       dcache_rdata,
  output logic              stall_out,
  output logic              w_valid,
  output logic              w_regwrite,
  output logic              w_memwrite,
  output logic [WIDTH-1:0]  w_rfdata,
  output logic [31:0]       w_aluout,
  output logic [2:0]        w_readtype,
  output logic [SIDE_W-1:0] w_side
);

  state_e      state_q, state_d;
  logic [31:0] buf_q;
  logic        req_wr_q;
  logic [1:0]  req_size_q;
  logic [31:0] req_addr_q, req_wdata_q;

  logic        exc_s, mem_op_s, req_s, stall_s, capture_s, use_buf_s, hold_s;
  logic [1:0]  size_s;
  logic [31:0] wdata_s, rsrc_s, aligned_s, rf32_s;

  assign exc_s    = (m_side[SIDE_EXC_LSB +: SIDE_EXC_W] != 4'd0);
  assign mem_op_s = m_valid & (m_memtoreg | m_memwrite) & ~exc_s & ~flush;
  assign size_s   = size_of(m_readtype);
  assign wdata_s  = store_lanes(size_s, m_wdata);

  // Request FSM: next state, request strobe, stall and buffer control.
  always_comb begin
    state_d   = state_q;
    req_s     = 1'b0;
    stall_s   = 1'b0;
    capture_s = 1'b0;
    use_buf_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s) begin
          req_s   = 1'b1;
          stall_s = 1'b1;
          state_d = dcache_addr_ok ? ST_WAIT : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          req_s   = 1'b1;
          stall_s = 1'b1;
          state_d = dcache_addr_ok ? ST_WAIT : ST_REQ;
        end
      end
      ST_WAIT: begin
        // A flush racing data_ok has nothing left to drain.
        if (flush) begin
          state_d = dcache_data_ok ? ST_IDLE : ST_DROP;
        end else if (dcache_data_ok) begin
          if (stall_in) begin
            capture_s = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_IDLE;
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      ST_DONE: begin
        use_buf_s = 1'b1;
        if (flush || !stall_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DROP: begin
        stall_s = mem_op_s;
        if (dcache_data_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot of the request so its fields stay stable while addr_ok is pending.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
    end else if ((state_q == ST_IDLE) && req_s && !dcache_addr_ok) begin
      req_wr_q    <= m_memwrite;
      req_size_q  <= size_s;
      req_addr_q  <= m_aluout;
      req_wdata_q <= wdata_s;
    end
  end

  // Read-data buffer for a completion that arrives while WB is held.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_q <= 32'd0;
    end else if (capture_s) begin
      buf_q <= dcache_rdata;
    end else if (use_buf_s && (flush || !stall_in)) begin
      buf_q <= 32'd0;
    end
  end

  assign hold_s       = (state_q == ST_REQ);
  assign dcache_req   = resetn & req_s;
  assign dcache_wr    = hold_s ? req_wr_q    : m_memwrite;
  assign dcache_size  = hold_s ? req_size_q  : size_s;
  assign dcache_addr  = hold_s ? req_addr_q  : m_aluout;
  assign dcache_wdata = hold_s ? req_wdata_q : wdata_s;
  assign stall_out    = resetn & stall_s;

  assign rsrc_s = use_buf_s ? buf_q : dcache_rdata;

  load_align u_load_align (
    .readtype_i (m_readtype),
    .addr_lo_i  (m_aluout[1:0]),
    .rdata_i    (rsrc_s),
    .data_o     (aligned_s)
  );

  assign rf32_s = m_memtoreg ? aligned_s : m_aluout;

  // WB register: hold on stall_in, bubble while MEM is stalled, else load.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_valid    <= 1'b0;
      w_regwrite <= 1'b0;
      w_memwrite <= 1'b0;
      w_rfdata   <= '0;
      w_aluout   <= 32'd0;
      w_readtype <= 3'd0;
      w_side     <= '0;
    end else if (stall_in) begin
      w_valid    <= w_valid;
    end else if (stall_s) begin
      w_valid    <= 1'b0;
      w_regwrite <= 1'b0;
      w_memwrite <= 1'b0;
    end else begin
      // Register-file writes of killed instructions are gated later in WB.
      w_valid    <= m_valid & ~flush;
      w_regwrite <= m_regwrite;
      w_memwrite <= m_memwrite & ~flush & ~exc_s;
      w_rfdata   <= WIDTH'(rf32_s);
      w_aluout   <= m_aluout;
      w_readtype <= m_readtype;
      w_side     <= m_side;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table plus handshake corner cases,
// WB writes checked through an expected-result queue.
`define CHK(n, a, e) chk(n, 128'(a), 128'(e))

module tb_mem_wb_stage;

  logic         clk = 1'b0;
  logic         resetn, flush, stall_in, m_valid;
  logic [31:0]  m_aluout, m_wdata;
  logic         m_memtoreg, m_regwrite, m_memwrite;
  logic [2:0]   m_readtype;
  logic [111:0] m_side;
  logic         dcache_req, dcache_wr;
  logic [1:0]   dcache_size;
  logic [31:0]  dcache_addr, dcache_wdata;
  logic         dcache_addr_ok, dcache_data_ok;
  logic [31:0]  dcache_rdata;
  logic         stall_out, w_valid, w_regwrite, w_memwrite;
  logic [31:0]  w_rfdata, w_aluout;
  logic [2:0]   w_readtype;
  logic [111:0] w_side;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .stall_in(stall_in), .m_valid(m_valid),
    .m_aluout(m_aluout), .m_wdata(m_wdata), .m_memtoreg(m_memtoreg), .m_regwrite(m_regwrite),
    .m_memwrite(m_memwrite), .m_readtype(m_readtype), .m_side(m_side),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_size(dcache_size),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata), .dcache_addr_ok(dcache_addr_ok),
    .dcache_data_ok(dcache_data_ok), .dcache_rdata(dcache_rdata), .stall_out(stall_out),
    .w_valid(w_valid), .w_regwrite(w_regwrite), .w_memwrite(w_memwrite), .w_rfdata(w_rfdata),
    .w_aluout(w_aluout), .w_readtype(w_readtype), .w_side(w_side)
  );

  typedef struct {
    logic [31:0]  rfdata;
    logic         regwrite;
    logic         memwrite;
    logic [111:0] side;
    logic [31:0]  aluout;
  } wb_exp_t;

  typedef struct {
    logic [2:0]  rt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mtr, mw, rw;
    logic [31:0] exp_rf;
    logic [1:0]  exp_size;
    logic [31:0] exp_wdata;
  } vec_t;

  wb_exp_t sb_q[$];
  vec_t    vecs[14];
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [111:0] mk_side(input logic [3:0] exc);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[7:4] = exc;
    return r[111:0];
  endfunction

  task automatic drive_idle();
    m_valid = 1'b0; m_memtoreg = 1'b0; m_memwrite = 1'b0; m_regwrite = 1'b0;
    m_aluout = 32'd0; m_wdata = 32'd0; m_readtype = 3'd0; m_side = '0;
    flush = 1'b0; dcache_addr_ok = 1'b0; dcache_data_ok = 1'b0; dcache_rdata = 32'd0;
  endtask

  task automatic set_instr(input logic [2:0] rt, input logic [31:0] a, input logic [31:0] wd,
                           input logic mtr, input logic mw, input logic rw, input logic [111:0] side);
    m_valid = 1'b1; m_readtype = rt; m_aluout = a; m_wdata = wd;
    m_memtoreg = mtr; m_memwrite = mw; m_regwrite = rw; m_side = side;
  endtask

  task automatic push_exp(input logic [31:0] rf, input logic rw, input logic mw,
                          input logic [111:0] side, input logic [31:0] a);
    wb_exp_t e;
    e.rfdata = rf; e.regwrite = rw; e.memwrite = mw; e.side = side; e.aluout = a;
    sb_q.push_back(e);
  endtask

  // WB monitor: every register load with w_valid=1 must match the queue head.
  always @(posedge clk) begin
    logic    live;
    wb_exp_t e;
    live = resetn & ~stall_in;
    #1;
    if (live && w_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual w_valid=1 required no WB write");
      end else begin
        e = sb_q.pop_front();
        `CHK("sb_rfdata", w_rfdata, e.rfdata);
        `CHK("sb_rw_mw", {w_regwrite, w_memwrite}, {e.regwrite, e.memwrite});
        `CHK("sb_side", w_side, e.side);
        `CHK("sb_aluout", w_aluout, e.aluout);
      end
    end
  end

  // One instruction with addr_ok on issue and data_ok one cycle later.
  task automatic run_vec(input vec_t v);
    logic         memop;
    logic [111:0] side;
    memop = v.mtr | v.mw;
    side  = mk_side(4'd0);
    @(negedge clk);
    set_instr(v.rt, v.addr, v.wdata, v.mtr, v.mw, v.rw, side);
    dcache_addr_ok = memop;
    push_exp(v.exp_rf, v.rw, v.mw, side, v.addr);
    #2;
    `CHK("vec_req", dcache_req, memop);
    `CHK("vec_stall", stall_out, memop);
    if (memop) begin
      `CHK("vec_addr", dcache_addr, v.addr);
      `CHK("vec_wr", dcache_wr, v.mw);
      `CHK("vec_size", dcache_size, v.exp_size);
      if (v.mw) `CHK("vec_wdata", dcache_wdata, v.exp_wdata);
      @(negedge clk);
      dcache_addr_ok = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = v.rdata;
      #2;
      `CHK("vec_stall_dataok", stall_out, 1'b0);
      `CHK("vec_req_wait", dcache_req, 1'b0);
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'h0000_1003, 32'h0,         32'h80AA_BBCC, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 2'd0, 32'h0};
    vecs[1]  = '{3'd2, 32'h0000_1001, 32'h0,         32'h80AA_BBCC, 1'b1, 1'b0, 1'b1, 32'h0000_00BB, 2'd0, 32'h0};
    vecs[2]  = '{3'd1, 32'h0000_1000, 32'h0,         32'h80AA_BBCC, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFCC, 2'd0, 32'h0};
    vecs[3]  = '{3'd3, 32'h0000_1002, 32'h0,         32'h8001_1234, 1'b1, 1'b0, 1'b1, 32'hFFFF_8001, 2'd1, 32'h0};
    vecs[4]  = '{3'd4, 32'h0000_1000, 32'h0,         32'hABCD_8765, 1'b1, 1'b0, 1'b1, 32'h0000_8765, 2'd1, 32'h0};
    vecs[5]  = '{3'd3, 32'h0000_1000, 32'h0,         32'h0000_7FFF, 1'b1, 1'b0, 1'b1, 32'h0000_7FFF, 2'd1, 32'h0};
    vecs[6]  = '{3'd0, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd2, 32'h0};
    vecs[7]  = '{3'd6, 32'h0000_1003, 32'h0,         32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 2'd2, 32'h0};
    vecs[8]  = '{3'd1, 32'h0000_2001, 32'h1234_56A5, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_2001, 2'd0, 32'hA5A5_A5A5};
    vecs[9]  = '{3'd3, 32'h0000_2002, 32'h9999_BEEF, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_2002, 2'd1, 32'hBEEF_BEEF};
    vecs[10] = '{3'd0, 32'h0000_2004, 32'h1122_3344, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_2004, 2'd2, 32'h1122_3344};
    vecs[11] = '{3'd0, 32'hCAFE_F00D, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 2'd2, 32'h0};
    vecs[12] = '{3'd1, 32'h0000_0003, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0003, 2'd0, 32'h0};
    vecs[13] = '{3'd2, 32'h0000_1002, 32'h0,         32'h80AA_BBCC, 1'b1, 1'b0, 1'b1, 32'h0000_00AA, 2'd0, 32'h0};

    resetn = 1'b0; stall_in = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    `CHK("rst_wb", {w_valid, w_regwrite, w_memwrite, w_rfdata, w_aluout, w_readtype}, 128'd0);
    `CHK("rst_side", w_side, 112'd0);
    `CHK("rst_req_stall", {dcache_req, stall_out}, 2'b00);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // addr_ok delayed three cycles: request held, WB bubbles
    begin
      logic [111:0] s;
      @(negedge clk);
      s = mk_side(4'd0);
      set_instr(3'd0, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0, 1'b1, s);
      push_exp(32'h0BAD_F00D, 1'b1, 1'b0, s, 32'h0BAD_F00D);
      @(negedge clk);
      s = mk_side(4'd0);
      set_instr(3'd4, 32'h0000_3002, 32'h0, 1'b1, 1'b0, 1'b1, s);
      push_exp(32'h0000_8001, 1'b1, 1'b0, s, 32'h0000_3002);
      for (int i = 0; i < 3; i++) begin
        #2;
        `CHK("dly_req", dcache_req, 1'b1);
        `CHK("dly_stall", stall_out, 1'b1);
        `CHK("dly_addr_size", {dcache_addr, dcache_size}, {32'h0000_3002, 2'd1});
        @(posedge clk);
        #1;
        `CHK("dly_bubble", w_valid, 1'b0);
        @(negedge clk);
      end
      dcache_addr_ok = 1'b1;
      #2;
      `CHK("dly_req_ack", dcache_req, 1'b1);
      @(negedge clk);
      dcache_addr_ok = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = 32'h8001_1234;
      @(negedge clk);
      drive_idle();
    end

    // data_ok under stall_in: buffered until stall_in drops
    begin
      logic [111:0] s;
      @(negedge clk);
      s = mk_side(4'd0);
      set_instr(3'd0, 32'h0000_4000, 32'h0, 1'b1, 1'b0, 1'b1, s);
      dcache_addr_ok = 1'b1;
      push_exp(32'h5555_AAAA, 1'b1, 1'b0, s, 32'h0000_4000);
      @(negedge clk);
      dcache_addr_ok = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = 32'h5555_AAAA; stall_in = 1'b1;
      @(posedge clk);
      #1;
      `CHK("done_hold1", w_valid, 1'b0);
      @(negedge clk);
      dcache_data_ok = 1'b0; dcache_rdata = 32'h1212_1212;
      #2;
      `CHK("done_stall_out", stall_out, 1'b0);
      `CHK("done_req", dcache_req, 1'b0);
      @(posedge clk);
      #1;
      `CHK("done_hold2", w_valid, 1'b0);
      @(negedge clk);
      stall_in = 1'b0;
      @(posedge clk);
      #1;
      `CHK("done_release", {w_valid, w_rfdata}, {1'b1, 32'h5555_AAAA});
      @(negedge clk);
      drive_idle();
    end

    // flush in WAIT: stale data_ok dropped, next load waits for it
    begin
      logic [111:0] s;
      @(negedge clk);
      set_instr(3'd0, 32'h0000_6000, 32'h0, 1'b1, 1'b0, 1'b1, mk_side(4'd0));
      dcache_addr_ok = 1'b1;
      @(negedge clk);
      dcache_addr_ok = 1'b0; flush = 1'b1;
      #2;
      `CHK("drop_flush_req", dcache_req, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      s = mk_side(4'd0);
      set_instr(3'd0, 32'h0000_6004, 32'h0, 1'b1, 1'b0, 1'b1, s);
      push_exp(32'h0000_0077, 1'b1, 1'b0, s, 32'h0000_6004);
      #2;
      `CHK("drop_req", {dcache_req, stall_out}, 2'b01);
      @(negedge clk);
      dcache_data_ok = 1'b1; dcache_rdata = 32'hFFFF_FFFF;
      #2;
      `CHK("drop_req_dataok", dcache_req, 1'b0);
      @(posedge clk);
      #1;
      `CHK("drop_no_wb", w_valid, 1'b0);
      @(negedge clk);
      dcache_data_ok = 1'b0; dcache_rdata = 32'd0; dcache_addr_ok = 1'b1;
      #2;
      `CHK("drop_new_req", {dcache_req, dcache_addr}, {1'b1, 32'h0000_6004});
      @(negedge clk);
      dcache_addr_ok = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = 32'h0000_0077;
      @(negedge clk);
      drive_idle();
    end

    // exception-carrying load/store bypass the dcache; flushed ALU op is a bubble
    begin
      logic [111:0] s;
      @(negedge clk);
      s = mk_side(4'd6);
      set_instr(3'd0, 32'h0000_0080, 32'h0, 1'b1, 1'b0, 1'b1, s);
      push_exp(32'h0, 1'b1, 1'b0, s, 32'h0000_0080);
      #2;
      `CHK("exc_ld_req_stall", {dcache_req, stall_out}, 2'b00);
      @(posedge clk);
      #1;
      `CHK("exc_ld_wb", {w_valid, w_side[7:4]}, {1'b1, 4'd6});
      @(negedge clk);
      s = mk_side(4'd6);
      set_instr(3'd0, 32'h0000_0088, 32'h0000_0055, 1'b0, 1'b1, 1'b0, s);
      push_exp(32'h0000_0088, 1'b0, 1'b0, s, 32'h0000_0088);
      #2;
      `CHK("exc_st_req", dcache_req, 1'b0);
      @(negedge clk);
      set_instr(3'd0, 32'h0000_0099, 32'h0, 1'b0, 1'b0, 1'b1, mk_side(4'd0));
      flush = 1'b1;
      @(posedge clk);
      #1;
      `CHK("flush_alu_wb", w_valid, 1'b0);
      @(negedge clk);
      set_instr(3'd0, 32'h0000_00A0, 32'h0, 1'b1, 1'b0, 1'b1, mk_side(4'd0));
      flush = 1'b1;
      #2;
      `CHK("flush_ld_req", dcache_req, 1'b0);
      @(negedge clk);
      drive_idle();
    end

    // reset in WAIT abandons the load
    begin
      logic [111:0] s;
      @(negedge clk);
      s = mk_side(4'd0);
      set_instr(3'd0, 32'h0000_7000, 32'h0, 1'b0, 1'b0, 1'b1, s);
      push_exp(32'h0000_7000, 1'b1, 1'b0, s, 32'h0000_7000);
      @(negedge clk);
      set_instr(3'd0, 32'h0000_5000, 32'h0, 1'b1, 1'b0, 1'b1, mk_side(4'd0));
      dcache_addr_ok = 1'b1;
      @(negedge clk);
      dcache_addr_ok = 1'b0;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      `CHK("rstw_wb", {w_valid, w_regwrite, w_memwrite, w_rfdata, w_aluout, w_readtype}, 128'd0);
      `CHK("rstw_side", w_side, 112'd0);
      `CHK("rstw_req_stall", {dcache_req, stall_out}, 2'b00);
      @(negedge clk);
      resetn = 1'b1;
      drive_idle();
    end
    run_vec(vecs[6]);

    repeat (3) @(negedge clk);
    `CHK("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of the register-file write data.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 flush  in  1  kill the instruction in MEM and any pending request.
REQ-005 stall_in  in  1  downstream/global hold; the WB register keeps its contents.
REQ-006 m_valid  in  1  MEM-stage instruction valid.
REQ-007 m_aluout  in  32  ALU result and memory address.
REQ-008 m_wdata  in  32  store data, LSB-aligned.
REQ-009 m_memtoreg / m_regwrite / m_memwrite  in  1 each  load select, RF write enable, store.
REQ-010 m_readtype  in  3  0=W, 1=B, 2=BU, 3=H, 4=HU; 5-7 treated as W.
REQ-011 m_side  in  112  sideband {waddr7, hilo64, hilo_we1, pc32, exc4, is_ds1, tlb_we1, tlb_cp0we2}, MSB first.
REQ-012 dcache_req  out  1; dcache_wr  out  1; dcache_size  out  2 (0=B, 1=H, 2=W); dcache_addr  out  32; dcache_wdata  out  32.
REQ-013 dcache_addr_ok / dcache_data_ok  in  1 each; dcache_rdata  in  32.
REQ-014 stall_out  out  1  MEM cannot retire this cycle.
REQ-015 w_valid, w_regwrite, w_memwrite  out  1 each; w_rfdata  out  WIDTH; w_aluout  out  32; w_readtype  out  3; w_side  out  112; all registered.

Function
REQ-016 A memory op is m_valid & (m_memtoreg | m_memwrite) & exc==0 & !flush; all other instructions bypass the dcache.
REQ-017 FSM states IDLE, REQ, WAIT, DONE, DROP; reset state IDLE.
REQ-018 IDLE: a memory op drives dcache_req=1 combinationally; addr_ok -> WAIT, else -> REQ.
REQ-019 REQ: hold dcache_req and all dcache_* fields stable until addr_ok -> WAIT; flush -> IDLE with no request issued.
REQ-020 WAIT: data_ok & !stall_in -> IDLE with WB load; data_ok & stall_in -> DONE, rdata captured in a buffer; flush -> DROP.
REQ-021 DONE: !stall_in -> IDLE with WB load from the buffer; flush -> IDLE, buffer discarded.
REQ-022 DROP: ignore data_ok data; on data_ok -> IDLE; a new request is not issued before that transition.
REQ-023 stall_out=1 when a memory op is present and completion is not available this cycle (IDLE/REQ, WAIT without data_ok, DROP); stall_out=0 in DONE.
REQ-024 Store: dcache_wr=1; size from m_readtype; wdata replicated per lane (byte x4, half x2).
REQ-025 Load align on m_aluout[1:0]: B/BU select byte a*8, H/HU select half a[1]*16; B/H sign-extend, BU/HU zero-extend.
REQ-026 w_rfdata = aligned load data if m_memtoreg, else m_aluout.
REQ-027 WB register: stall_in -> hold; !stall_in & stall_out -> bubble (w_valid, w_regwrite, w_memwrite = 0); otherwise load with w_valid = m_valid & !flush.
REQ-028 A flushed or exception-carrying instruction writes WB with w_memwrite=0; w_regwrite passes unchanged, because WB gating handles it.
REQ-029 Latency: a non-memory instruction reaches WB 1 cycle after MEM; a load reaches WB 1 cycle after data_ok.

Reset
REQ-030 On resetn=0 at the clock edge: FSM=IDLE; w_valid, w_regwrite, w_memwrite, w_rfdata, w_aluout, w_readtype, w_side, and the buffer =0; dcache_req=0.
REQ-031 Reset mid-request abandons the transaction; the dcache is reset by the same resetn.

Structure
REQ-032 The shared package holds m_side field offsets/width, readtype encodings, dcache_size encodings, and the FSM state enum.
REQ-033 Load alignment/extension is one combinational sub-module, load_align.

Verification
REQ-034 LB, aluout=0x...3, rdata=0x80AABBCC, data_ok in WAIT -> next cycle w_rfdata=0xFFFFFF80, w_regwrite=1.
REQ-035 LHU, addr[1]=1, rdata=0x8001_1234 -> w_rfdata=0x00008001; addr_ok delayed 3 cycles -> req held, stall_out=1 for 3 cycles, WB gets bubbles.
REQ-036 data_ok while stall_in=1 for 2 cycles -> DONE, WB held; stall_in drops -> buffered data written, w_valid=1.
REQ-037 flush in WAIT -> DROP; data_ok then ignored; next load issues req only after that data_ok.
REQ-038 exc=6 on a load -> no dcache_req, passes in 1 cycle with w_memwrite=0, w_side.exc=6; reset asserted in WAIT -> all outputs 0 next cycle.
